ili9341_rgb_timing: RTL and testbench
=====================================

// Module: ili9341_rgb_timing
// PURPOSE
//  Consumes the PLL dot clock and drives the ILI9341 18-bit RGB parallel interface.
//  Generates HSYNC, VSYNC and DE, and pulls pixels from an upstream valid/ready stream.
//  Sits between the frame source and the panel pins, in the dot-clock domain.
// PARAMETERS
//  H_SYNC   10   HSYNC low width, dot clocks
//  H_BP     20   horizontal back porch
//  H_ACT    240  active pixels per line
//  H_FP     10   horizontal front porch
//  V_SYNC   2    VSYNC low width, lines
//  V_BP     2    vertical back porch
//  V_ACT    320  active lines
//  V_FP     4    vertical front porch
//  UF_COLOR 18'h0 colour driven when the stream underflows
// PORTS
//  clock_in        in  1  dot clock from the PLL
//  reset           in  1  synchronous, active-high
//  pll_locked      in  1  PLL lock; low holds the block idle
//  pix_data        in  18 upstream pixel {R6,G6,B6}
//  pix_valid       in  1  pix_data valid
//  pix_ready       out 1  block takes pix_data this cycle
//  clear_underflow in  1  clears the underflow flag
//  lcd_hsync       out 1  active low
//  lcd_vsync       out 1  active low
//  lcd_de          out 1  active high
//  lcd_rgb         out 18 pixel bus
//  frame_start     out 1  1-cycle pulse, first active pixel of each frame
//  underflow       out 1  sticky flag
// BEHAVIOUR
//  - Reset values: hsync=1, vsync=1, de=0, rgb=0, pix_ready=0, frame_start=0, underflow=0.
//    Counters h=0, v=0; FSM in WAIT_LOCK.
//  - FSM WAIT_LOCK -> RUN when pll_locked=1, sampled at a clock edge.
//  - FSM RUN -> WAIT_LOCK on any cycle with pll_locked=0, including mid-frame.
//    Counters return to 0 and outputs return to their reset values the next cycle.
//  - H_TOTAL = sum of the H_* parameters (default 280). V_TOTAL = sum of the V_* parameters (default 328).
//  - Counter widths are $clog2 of the respective total.
//  - h increments every RUN cycle. At H_TOTAL-1, h wraps to 0 and v increments.
//  - v wraps to 0 at V_TOTAL-1 when h also wraps.
//  - Line order by h: SYNC [0, H_SYNC), BP, ACT, FP. The frame uses the same order by v.
//  - act = (h in ACT) && (v in ACT). pix_ready = act, combinational from the counters.
//  - All lcd_* outputs and frame_start are registered, one cycle after the counter state.
//    hsync, vsync, de and rgb therefore stay mutually aligned.
//  - hsync = !(h in H SYNC). vsync = !(v in V SYNC); vsync edges coincide with hsync falling (h=0).
//  - de = act, delayed one cycle.
//  - act && pix_valid: rgb <= pix_data; the transfer completes.
//  - act && !pix_valid: rgb <= UF_COLOR and underflow <= 1. The line is not stalled; timing never slips.
//  - !act: rgb <= 0, and pix_data is ignored.
//  - underflow is cleared by clear_underflow. If a new underflow occurs in the same cycle, the set wins.
//  - frame_start = 1 for the cycle where de first rises with v=V_SYNC+V_BP.
// CONFIGURATION
//  - Macro ILI9341_TEST_PATTERN_EN adds the input port test_pattern (1 bit).
//  - When test_pattern=1: rgb in ACT shows 8 vertical colour bars, each 30 pixels wide.
//    Colour order: white, yellow, cyan, green, magenta, red, blue, black.
//  - When test_pattern=1: pix_ready=0, and underflow is never set.
//  - Without the macro the port is absent and only the stream path exists.
// STRUCTURE
//  - Package ili9341_pkg holds the default timing constants, the 18-bit pixel type,
//    the FSM state enum (WAIT_LOCK, RUN) and the colour-bar constants.
//  - Sub-module ili9341_axis_counter (one per axis) provides:
//    count, wrap strobe, and region decode for SYNC/BP/ACT/FP.
//  - It is instantiated for H, with enable = RUN, and for V, with enable = H wrap.
// TESTING
//  1. Reset, then lock=1 with pix_valid=1 constantly. Check that:
//     - hsync is low for 10 of every 280 cycles;
//     - de is high for 240 cycles per line, starting 30 cycles after hsync falls;
//     - vsync is low for 2 lines;
//     - the frame period is 91840 cycles.
//  2. Stream incrementing data. Check that:
//     - rgb on the first de cycle equals the first accepted word;
//     - 76800 words are accepted per frame;
//     - frame_start pulses exactly once per frame.
//  3. Drop pix_valid for 5 active cycles. Check that:
//     - rgb equals UF_COLOR for those cycles;
//     - underflow is set and de timing is unchanged;
//     - clear_underflow pulsed with no further underflow clears the flag.
//  4. Deassert pll_locked at line 100, pixel 50. Check that:
//     - the next cycle shows hsync=1, vsync=1, de=0;
//     - after relock, the first hsync fall occurs one cycle after RUN entry (counters at 0).
//  5. Apply reset mid-active-line. Check that all outputs return to reset values next cycle
//     and that underflow is cleared.
//  6. With ILI9341_TEST_PATTERN_EN and test_pattern=1, check that:
//     - active pixels 0, 30 and 239 show 18'h3FFFF, 18'h3FFC0 and 18'h0;
//     - pix_ready stays 0.

Source files
------------

// File: rtl/ili9341_pkg.sv
// Shared timing defaults, pixel/state/region types and the colour-bar palette
// for the ILI9341 18-bit RGB timing generator.
package ili9341_pkg;
  localparam int H_SYNC_DEF = 10;
  localparam int H_BP_DEF   = 20;
  localparam int H_ACT_DEF  = 240;
  localparam int H_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 2;
  localparam int V_ACT_DEF  = 320;
  localparam int V_FP_DEF   = 4;

  typedef logic [17:0] pixel_t;
  localparam pixel_t UF_COLOR_DEF = 18'h0;

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {REG_SYNC, REG_BP, REG_ACT, REG_FP} region_t;

  // {R6,G6,B6}, left to right across the active line
  localparam pixel_t BAR_WHITE   = 18'h3FFFF;
  localparam pixel_t BAR_YELLOW  = 18'h3FFC0;
  localparam pixel_t BAR_CYAN    = 18'h00FFF;
  localparam pixel_t BAR_GREEN   = 18'h00FC0;
  localparam pixel_t BAR_MAGENTA = 18'h3F03F;
  localparam pixel_t BAR_RED     = 18'h3F000;
  localparam pixel_t BAR_BLUE    = 18'h0003F;
  localparam pixel_t BAR_BLACK   = 18'h00000;

  function automatic pixel_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction
endpackage

// File: rtl/ili9341_axis_counter.sv
// One timing axis: position counter with wrap strobe and SYNC/BP/ACT/FP region decode.
module ili9341_axis_counter
  import ili9341_pkg::*;
#(
  parameter int SYNC = 10,
  parameter int BP   = 20,
  parameter int ACT  = 240,
  parameter int FP   = 10,
  localparam int TOTAL = SYNC + BP + ACT + FP,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap,
  output region_t      region
);
  localparam logic [W-1:0] BP_START  = W'(SYNC);
  localparam logic [W-1:0] ACT_START = W'(SYNC + BP);
  localparam logic [W-1:0] FP_START  = W'(SYNC + BP + ACT);
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  always_comb begin
    region = REG_FP;
    if (count < BP_START)       region = REG_SYNC;
    else if (count < ACT_START) region = REG_BP;
    else if (count < FP_START)  region = REG_ACT;
  end
endmodule

// File: rtl/ili9341_rgb_timing.sv
// ILI9341 RGB-interface timing generator: HSYNC/VSYNC/DE plus valid/ready pixel fetch.
// Defining ILI9341_TEST_PATTERN_EN adds a test_pattern input that shows 8 colour bars.
module ili9341_rgb_timing
  import ili9341_pkg::*;
#(
  parameter int     H_SYNC   = H_SYNC_DEF,
  parameter int     H_BP     = H_BP_DEF,
  parameter int     H_ACT    = H_ACT_DEF,
  parameter int     H_FP     = H_FP_DEF,
  parameter int     V_SYNC   = V_SYNC_DEF,
  parameter int     V_BP     = V_BP_DEF,
  parameter int     V_ACT    = V_ACT_DEF,
  parameter int     V_FP     = V_FP_DEF,
  parameter pixel_t UF_COLOR = UF_COLOR_DEF
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic [17:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        clear_underflow,
`ifdef ILI9341_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_de,
  output logic [17:0] lcd_rgb,
  output logic        frame_start,
  output logic        underflow
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  state_t         state;
  logic           running;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           h_wrap;
  logic           v_wrap_unused;
  region_t        h_region;
  region_t        v_region;
  logic           act;
  logic           first_px;
  logic           starve;
  pixel_t         act_rgb;

  // Losing lock acts in the same cycle, so counters and outputs are idle on the next one
  assign running = (state == RUN) && pll_locked;

  ili9341_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) h_axis (
    .clk(clock_in), .srst(reset), .en(running), .clr(!running),
    .count(h_count), .wrap(h_wrap), .region(h_region)
  );

  ili9341_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) v_axis (
    .clk(clock_in), .srst(reset), .en(h_wrap), .clr(!running),
    .count(v_count), .wrap(v_wrap_unused), .region(v_region)
  );

  assign act      = running && (h_region == REG_ACT) && (v_region == REG_ACT);
  assign first_px = (h_count == H_W'(H_SYNC + H_BP)) && (v_count == V_W'(V_SYNC + V_BP));

`ifdef ILI9341_TEST_PATTERN_EN
  logic [H_W-1:0] tp_offset;
  logic [2:0]     tp_bar;

  assign tp_offset = h_count - H_W'(H_SYNC + H_BP);
  assign tp_bar    = 3'(tp_offset / H_W'(H_ACT / 8));
  assign pix_ready = act && !test_pattern;
  assign starve    = pix_ready && !pix_valid;
  assign act_rgb   = test_pattern ? bar_color(tp_bar) : (pix_valid ? pix_data : UF_COLOR);
`else
  assign pix_ready = act;
  assign starve    = act && !pix_valid;
  assign act_rgb   = pix_valid ? pix_data : UF_COLOR;
`endif

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: if (pll_locked) state <= RUN;
        RUN:       if (!pll_locked) state <= WAIT_LOCK;
      endcase
      if (!running) begin
        lcd_hsync   <= 1'b1;
        lcd_vsync   <= 1'b1;
        lcd_de      <= 1'b0;
        lcd_rgb     <= '0;
        frame_start <= 1'b0;
        underflow   <= 1'b0;
      end else begin
        lcd_hsync   <= (h_region != REG_SYNC);
        lcd_vsync   <= (v_region != REG_SYNC);
        lcd_de      <= act;
        lcd_rgb     <= act ? act_rgb : '0;
        frame_start <= act && first_px;
        // A fresh starvation beats a simultaneous clear
        if (starve)               underflow <= 1'b1;
        else if (clear_underflow) underflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ili9341_rgb_timing.sv
// Directed bench for ili9341_rgb_timing with a shortened frame (12 lines) to keep runs short.
module tb_ili9341_rgb_timing;
  localparam int HT    = 280;
  localparam int FRAME = HT * 12;
  localparam int ACT0  = 4 * HT + 30;
  localparam logic [17:0] UF = 18'h2AAAA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pll_locked = 1'b0;
  logic [17:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        clear_underflow = 1'b0;
`ifdef ILI9341_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif
  logic        lcd_hsync, lcd_vsync, lcd_de, frame_start, underflow;
  logic [17:0] lcd_rgb;

  int n_cmp = 0;
  int n_err = 0;
  int cnt   = 0;

  always #5 clk = ~clk;

  ili9341_rgb_timing #(
    .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(2), .UF_COLOR(UF)
  ) dut (
    .clock_in(clk), .reset(reset), .pll_locked(pll_locked),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .clear_underflow(clear_underflow),
`ifdef ILI9341_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb), .frame_start(frame_start), .underflow(underflow)
  );

  // cnt tracks the counter position the DUT holds after this edge
  task automatic step;
    @(posedge clk);
    #1;
    cnt = (cnt + 1) % FRAME;
  endtask

  task automatic wait_cnt(input int target);
    while (cnt != target) step();
  endtask

  task automatic test_reset;
    reset = 1'b1; pll_locked = 1'b0; pix_valid = 1'b1; pix_data = 18'h15555;
    repeat (3) step();
    n_cmp++; if (lcd_hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync got %b want 1", lcd_hsync); end
    n_cmp++; if (lcd_vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync got %b want 1", lcd_vsync); end
    n_cmp++; if (lcd_de !== 1'b0) begin n_err++; $display("FAIL reset_de got %b want 0", lcd_de); end
    n_cmp++; if (lcd_rgb !== 18'h0) begin n_err++; $display("FAIL reset_rgb got %h want 0", lcd_rgb); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", pix_ready); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", frame_start); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_uf got %b want 0", underflow); end
    pll_locked = 1'b1;
    repeat (3) step();
    n_cmp++; if (lcd_hsync !== 1'b1) begin n_err++; $display("FAIL reset_over_lock got hsync=%b want 1", lcd_hsync); end
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_timing;
    int k, hs_low, vs_low, de_hi, fs_cnt, first_de;
    logic vprev;
    reset = 1'b0; pix_valid = 1'b1; pix_data = 18'h01234;
    k = 0;
    do begin step(); k++; end while (lcd_hsync !== 1'b0 && k < 20);
    n_cmp++; if (k != 2) begin n_err++; $display("FAIL lock_to_hsync got %0d cycles want 2", k); end
    cnt = 1;
    hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0; first_de = -1; vprev = 1'b1;
    for (int s = 0; s < FRAME; s++) begin
      if (lcd_hsync === 1'b0) hs_low++;
      if (lcd_vsync === 1'b0) vs_low++;
      if (lcd_de === 1'b1) begin de_hi++; if (first_de < 0) first_de = s; end
      if (frame_start === 1'b1) fs_cnt++;
      vprev = lcd_vsync;
      step();
    end
    n_cmp++; if (hs_low != 120) begin n_err++; $display("FAIL hsync_low got %0d want 120", hs_low); end
    n_cmp++; if (vs_low != 560) begin n_err++; $display("FAIL vsync_low got %0d want 560", vs_low); end
    n_cmp++; if (de_hi != 1440) begin n_err++; $display("FAIL de_high got %0d want 1440", de_hi); end
    n_cmp++; if (first_de != ACT0) begin n_err++; $display("FAIL de_start got %0d want %0d", first_de, ACT0); end
    n_cmp++; if (fs_cnt != 1) begin n_err++; $display("FAIL frame_start_count got %0d want 1", fs_cnt); end
    n_cmp++; if (!(vprev === 1'b1 && lcd_vsync === 1'b0 && lcd_hsync === 1'b0)) begin
      n_err++; $display("FAIL frame_period got vprev=%b vsync=%b hsync=%b want 1 0 0", vprev, lcd_vsync, lcd_hsync);
    end
    $display("test_timing done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_stream;
    logic [17:0] word, exp;
    logic [17:0] q[$];
    int acc, pops, bad, fs;
    logic first_seen;
    word = 18'h00100; acc = 0; pops = 0; bad = 0; fs = 0; first_seen = 1'b0;
    pix_valid = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      pix_data = word;
      if (pix_ready === 1'b1) begin q.push_back(word); word++; acc++; end
      step();
      if (frame_start === 1'b1) fs++;
      if (lcd_de === 1'b1) begin
        pops++;
        if (!first_seen) begin
          first_seen = 1'b1;
          n_cmp++; if (lcd_rgb !== 18'h00100) begin n_err++; $display("FAIL first_pixel got %h want 00100", lcd_rgb); end
        end
        if (q.size() == 0) bad++;
        else begin exp = q.pop_front(); if (lcd_rgb !== exp) bad++; end
      end
    end
    n_cmp++; if (acc != 1440) begin n_err++; $display("FAIL accepted got %0d want 1440", acc); end
    n_cmp++; if (pops != 1440) begin n_err++; $display("FAIL de_pixels got %0d want 1440", pops); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stream_data got %0d wrong want 0", bad); end
    n_cmp++; if (fs != 1) begin n_err++; $display("FAIL stream_fs got %0d want 1", fs); end
    $display("test_stream done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_underflow;
    int de_cnt, de_gap, bad_uf;
    logic uf_before, uf_at;
    logic [17:0] rgb15;
    pix_valid = 1'b1; pix_data = 18'h0ABCD;
    de_cnt = 0; de_gap = 0; bad_uf = 0; uf_before = 1'bx; uf_at = 1'bx; rgb15 = 'x;
    wait_cnt(ACT0);
    for (int i = 0; i < HT; i++) begin
      pix_valid = !(i >= 10 && i < 15);
      step();
      if (lcd_de === 1'b1) de_cnt++;
      if (i < 240 && lcd_de !== 1'b1) de_gap++;
      if (i >= 10 && i < 15 && lcd_rgb !== UF) bad_uf++;
      if (i == 9) uf_before = underflow;
      if (i == 10) uf_at = underflow;
      if (i == 15) rgb15 = lcd_rgb;
    end
    n_cmp++; if (bad_uf != 0) begin n_err++; $display("FAIL uf_color got %0d wrong want 0", bad_uf); end
    n_cmp++; if (de_cnt != 240 || de_gap != 0) begin n_err++; $display("FAIL uf_de_timing got cnt=%0d gaps=%0d want 240 0", de_cnt, de_gap); end
    n_cmp++; if (uf_before !== 1'b0) begin n_err++; $display("FAIL uf_before got %b want 0", uf_before); end
    n_cmp++; if (uf_at !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", uf_at); end
    n_cmp++; if (rgb15 !== 18'h0ABCD) begin n_err++; $display("FAIL uf_resume got %h want 0abcd", rgb15); end
    pix_valid = 1'b0; clear_underflow = 1'b1;
    step();
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_wins got %b want 1", underflow); end
    pix_valid = 1'b1;
    step();
    clear_underflow = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear got %b want 0", underflow); end
    $display("test_underflow done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_lock_loss;
    pix_valid = 1'b1; pix_data = 18'h33333;
    wait_cnt(6 * HT + 80);
    n_cmp++; if (lcd_de !== 1'b1) begin n_err++; $display("FAIL lock_pre_de got %b want 1", lcd_de); end
    pll_locked = 1'b0;
    step();
    n_cmp++; if (lcd_hsync !== 1'b1 || lcd_vsync !== 1'b1) begin n_err++; $display("FAIL lock_syncs got %b%b want 11", lcd_hsync, lcd_vsync); end
    n_cmp++; if (lcd_de !== 1'b0) begin n_err++; $display("FAIL lock_de got %b want 0", lcd_de); end
    n_cmp++; if (lcd_rgb !== 18'h0) begin n_err++; $display("FAIL lock_rgb got %h want 0", lcd_rgb); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL lock_ready got %b want 0", pix_ready); end
    repeat (3) step();
    pll_locked = 1'b1;
    step();
    n_cmp++; if (lcd_hsync !== 1'b1) begin n_err++; $display("FAIL relock_entry got hsync=%b want 1", lcd_hsync); end
    step();
    n_cmp++; if (lcd_hsync !== 1'b0 || lcd_vsync !== 1'b0) begin n_err++; $display("FAIL relock_fall got %b%b want 00", lcd_hsync, lcd_vsync); end
    cnt = 1;
    $display("test_lock_loss done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_reset_mid;
    pix_valid = 1'b1; pix_data = 18'h12345;
    wait_cnt(ACT0 + 100);
    pix_valid = 1'b0;
    step();
    n_cmp++; if (lcd_de !== 1'b1 || underflow !== 1'b1) begin n_err++; $display("FAIL rmid_pre got de=%b uf=%b want 1 1", lcd_de, underflow); end
    reset = 1'b1; pix_valid = 1'b1; pix_data = 18'h3FFFF;
    step();
    n_cmp++; if (lcd_hsync !== 1'b1 || lcd_vsync !== 1'b1) begin n_err++; $display("FAIL rmid_syncs got %b%b want 11", lcd_hsync, lcd_vsync); end
    n_cmp++; if (lcd_de !== 1'b0 || lcd_rgb !== 18'h0) begin n_err++; $display("FAIL rmid_de_rgb got %b %h want 0 0", lcd_de, lcd_rgb); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rmid_uf got %b want 0", underflow); end
    n_cmp++; if (pix_ready !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL rmid_ready_fs got %b %b want 0 0", pix_ready, frame_start); end
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (lcd_hsync !== 1'b0) begin n_err++; $display("FAIL rmid_restart got hsync=%b want 0", lcd_hsync); end
    cnt = 1;
    $display("test_reset_mid done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

`ifdef ILI9341_TEST_PATTERN_EN
  task automatic test_pattern_bars;
    logic [17:0] p0, p30, p60, p239;
    int rdy_bad;
    rdy_bad = 0;
    test_pattern = 1'b1; pix_valid = 1'b0;
    wait_cnt(ACT0);
    for (int i = 0; i < 240; i++) begin
      if (pix_ready !== 1'b0) rdy_bad++;
      step();
      if (i == 0) p0 = lcd_rgb;
      if (i == 30) p30 = lcd_rgb;
      if (i == 60) p60 = lcd_rgb;
      if (i == 239) p239 = lcd_rgb;
    end
    n_cmp++; if (p0 !== 18'h3FFFF) begin n_err++; $display("FAIL tp_px0 got %h want 3ffff", p0); end
    n_cmp++; if (p30 !== 18'h3FFC0) begin n_err++; $display("FAIL tp_px30 got %h want 3ffc0", p30); end
    n_cmp++; if (p60 !== 18'h00FFF) begin n_err++; $display("FAIL tp_px60 got %h want 00fff", p60); end
    n_cmp++; if (p239 !== 18'h0) begin n_err++; $display("FAIL tp_px239 got %h want 0", p239); end
    n_cmp++; if (rdy_bad != 0) begin n_err++; $display("FAIL tp_ready got %0d high want 0", rdy_bad); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL tp_uf got %b want 0", underflow); end
    test_pattern = 1'b0;
    $display("test_pattern_bars done: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_stream();
    test_underflow();
    test_lock_loss();
    test_reset_mid();
`ifdef ILI9341_TEST_PATTERN_EN
    test_pattern_bars();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
